thunder_sequencer: RTL and testbench

- Sequencer for the Thunderbird tail-light display decoder.
- Turns raw switch inputs (left, right, hazard) into the 2-bit mode code and 8-bit sweep counter that the decoder consumes.
  - The decoder uses the counter to stage 1-4 LEDs per side, or to flash all of them in hazard mode.
- Sits between board switches and the decoder. Owns input synchronisation, prescaling, mode arbitration and sequence timing.

---
 rtl/thunder_sequencer.sv | 146 ++++++++++++++
 tb/tb_thunder_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thunder_sequencer.sv
// Thunderbird tail-light sequencer: switch synchronisation, mode arbitration and sweep timing.
// Optional per-switch debouncing is enabled by defining THUNDER_DEBOUNCE_EN.
module thunder_sequencer #(
    parameter int TICK_DIV   = 625000,
    parameter int CTN_MAX    = 79,
    parameter int DEB_CYCLES = 500000
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       left_sw,
    input  logic       right_sw,
    input  logic       hazard_sw,
    output logic [1:0] state,
    output logic [7:0] ctn,
    output logic       tick,
    output logic       seq_end
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        HAZ   = 2'd3
    } mode_t;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]    CTN_LAST   = 8'(CTN_MAX);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("thunder_sequencer: TICK_DIV must be at least 2");
    end
    if (CTN_MAX > 255 || CTN_MAX < 0) begin : g_bad_ctn_max
        $error("thunder_sequencer: CTN_MAX must be in 0..255");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
        $error("thunder_sequencer: DEB_CYCLES must be at least 1");
    end

    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] sw;

    // Bit order throughout: {hazard, right, left}.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {hazard_sw, right_sw, left_sw};
            sync2 <= sync1;
        end
    end

`ifdef THUNDER_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);

    logic [2:0]    deb_val;
    logic [DW-1:0] deb_cnt [3];

    // A new level is accepted only after DEB_CYCLES consecutive cycles; any reversion restarts.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            deb_val <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != deb_val[i]) begin
                    if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                        deb_val[i] <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign sw = deb_val;
`else
    assign sw = sync2;
`endif

    mode_t req;

    always_comb begin
        req = IDLE;
        if (sw[2] || (sw[0] && sw[1])) begin
            req = HAZ;
        end else if (sw[0]) begin
            req = LEFT;
        end else if (sw[1]) begin
            req = RIGHT;
        end
    end

    mode_t         state_q;
    logic [PW-1:0] presc;
    logic          at_step;

    assign at_step = (presc == PRESC_LAST);
    assign state   = state_q;

    // Mode changes other than hazard preemption are deferred to the wrap step so a sweep always
    // completes; a wrap that lands in IDLE suppresses its pulses so nothing fires while idle.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= IDLE;
            presc   <= '0;
            ctn     <= '0;
            tick    <= 1'b0;
            seq_end <= 1'b0;
        end else begin
            tick    <= 1'b0;
            seq_end <= 1'b0;
            if (state_q == IDLE) begin
                presc   <= '0;
                ctn     <= '0;
                state_q <= req;
            end else if (state_q != HAZ && req == HAZ) begin
                state_q <= HAZ;
                presc   <= '0;
                ctn     <= '0;
            end else if (at_step) begin
                presc <= '0;
                if (ctn == CTN_LAST) begin
                    ctn     <= '0;
                    state_q <= req;
                    tick    <= (req != IDLE);
                    seq_end <= (req != IDLE);
                end else begin
                    ctn  <= ctn + 8'd1;
                    tick <= 1'b1;
                end
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_thunder_sequencer.sv
// Directed self-checking bench for thunder_sequencer (TICK_DIV=4, CTN_MAX=7, DEB_CYCLES=3).
// Switch-to-state latency grows by DEB_CYCLES when THUNDER_DEBOUNCE_EN is defined.
module tb_thunder_sequencer;

    localparam int TICK_DIV   = 4;
    localparam int CTN_MAX    = 7;
    localparam int DEB_CYCLES = 3;
`ifdef THUNDER_DEBOUNCE_EN
    localparam int LAT = DEB_CYCLES + 3;
`else
    localparam int LAT = 3;
`endif

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       left_sw = 1'b0;
    logic       right_sw = 1'b0;
    logic       hazard_sw = 1'b0;
    logic [1:0] state;
    logic [7:0] ctn;
    logic       tick;
    logic       seq_end;

    int checks = 0;
    int fails  = 0;

    thunder_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .CTN_MAX   (CTN_MAX),
        .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .left_sw  (left_sw),
        .right_sw (right_sw),
        .hazard_sw(hazard_sw),
        .state    (state),
        .ctn      (ctn),
        .tick     (tick),
        .seq_end  (seq_end)
    );

    always #5 Clock = ~Clock;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic test_reset;
        logic [11:0] obs;
        Resetn = 1'b0;
        left_sw = 1'b0; right_sw = 1'b0; hazard_sw = 1'b0;
        step(2);
        obs = {state, ctn, tick, seq_end};
        checks++;
        if (obs !== 12'h000) begin
            fails++;
            $display("[TB] FAIL reset_state: got %h want 000", obs);
        end
        Resetn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(1);
            obs = {state, ctn, tick, seq_end};
            checks++;
            if (obs !== 12'h000) begin
                fails++;
                $display("[TB] FAIL idle_quiet cycle %0d: got %h want 000", i, obs);
            end
        end
    endtask

    task automatic test_left_sweep;
        logic [11:0] obs;
        logic [11:0] exp;
        left_sw = 1'b1;
        step(LAT - 1);
        checks++;
        if (state !== 2'd0) begin
            fails++;
            $display("[TB] FAIL left_early: state got %0d want 0", state);
        end
        step(1);
        obs = {state, ctn, tick, seq_end};
        checks++;
        if (obs !== {2'd1, 8'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("[TB] FAIL left_entry: got %h want %h", obs, {2'd1, 8'd0, 2'b00});
        end
        for (int k = 1; k <= CTN_MAX + 1; k++) begin
            step(TICK_DIV - 1);
            exp = {2'd1, 8'(k - 1), 1'b0, 1'b0};
            obs = {state, ctn, tick, seq_end};
            checks++;
            if (obs !== exp) begin
                fails++;
                $display("[TB] FAIL left_hold k=%0d: got %h want %h", k, obs, exp);
            end
            step(1);
            exp = {2'd1, 8'(k % (CTN_MAX + 1)), 1'b1, (k == CTN_MAX + 1)};
            obs = {state, ctn, tick, seq_end};
            checks++;
            if (obs !== exp) begin
                fails++;
                $display("[TB] FAIL left_step k=%0d: got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_hazard_preempt;
        logic [11:0] obs;
        step(3 * TICK_DIV);
        checks++;
        if (ctn !== 8'd3) begin
            fails++;
            $display("[TB] FAIL preempt_setup: ctn got %0d want 3", ctn);
        end
        hazard_sw = 1'b1;
        step(LAT - 1);
        checks++;
        if (state !== 2'd1) begin
            fails++;
            $display("[TB] FAIL preempt_early: state got %0d want 1", state);
        end
        step(1);
        obs = {state, ctn, tick, seq_end};
        checks++;
        if (obs !== {2'd3, 8'd0, 2'b00}) begin
            fails++;
            $display("[TB] FAIL preempt_entry: got %h want %h", obs, {2'd3, 8'd0, 2'b00});
        end
        step(2 * TICK_DIV);
        checks++;
        if ({state, ctn} !== {2'd3, 8'd2}) begin
            fails++;
            $display("[TB] FAIL hazard_ctn2: got %h want %h", {state, ctn}, {2'd3, 8'd2});
        end
        hazard_sw = 1'b0;
        step(6 * TICK_DIV - 1);
        checks++;
        if ({state, ctn} !== {2'd3, 8'd7}) begin
            fails++;
            $display("[TB] FAIL hazard_hold: got %h want %h", {state, ctn}, {2'd3, 8'd7});
        end
        step(1);
        obs = {state, ctn, tick, seq_end};
        checks++;
        if (obs !== {2'd1, 8'd0, 2'b11}) begin
            fails++;
            $display("[TB] FAIL hazard_release: got %h want %h", obs, {2'd1, 8'd0, 2'b11});
        end
    endtask

    task automatic test_left_to_idle;
        logic [11:0] obs;
        left_sw = 1'b0;
        step((CTN_MAX + 1) * TICK_DIV - 1);
        checks++;
        if ({state, ctn} !== {2'd1, 8'd7}) begin
            fails++;
            $display("[TB] FAIL idle_pending: got %h want %h", {state, ctn}, {2'd1, 8'd7});
        end
        step(1);
        obs = {state, ctn, tick, seq_end};
        checks++;
        if (obs !== 12'h000) begin
            fails++;
            $display("[TB] FAIL idle_at_wrap: got %h want 000", obs);
        end
        step(10);
        obs = {state, ctn, tick, seq_end};
        checks++;
        if (obs !== 12'h000) begin
            fails++;
            $display("[TB] FAIL idle_stays: got %h want 000", obs);
        end
    endtask

    task automatic test_direction_change;
        logic [11:0] obs;
        right_sw = 1'b1;
        step(LAT);
        checks++;
        if ({state, ctn} !== {2'd2, 8'd0}) begin
            fails++;
            $display("[TB] FAIL right_entry: got %h want %h", {state, ctn}, {2'd2, 8'd0});
        end
        step(2 * TICK_DIV);
        checks++;
        if (ctn !== 8'd2) begin
            fails++;
            $display("[TB] FAIL right_ctn2: ctn got %0d want 2", ctn);
        end
        right_sw = 1'b0;
        left_sw = 1'b1;
        step(6 * TICK_DIV - 1);
        checks++;
        if ({state, ctn} !== {2'd2, 8'd7}) begin
            fails++;
            $display("[TB] FAIL right_hold: got %h want %h", {state, ctn}, {2'd2, 8'd7});
        end
        step(1);
        obs = {state, ctn, tick, seq_end};
        checks++;
        if (obs !== {2'd1, 8'd0, 2'b11}) begin
            fails++;
            $display("[TB] FAIL right_to_left: got %h want %h", obs, {2'd1, 8'd0, 2'b11});
        end
    endtask

    task automatic test_both_then_reset;
        logic [11:0] obs;
        Resetn = 1'b0;
        left_sw = 1'b0;
        right_sw = 1'b0;
        step(1);
        Resetn = 1'b1;
        step(2);
        left_sw = 1'b1;
        right_sw = 1'b1;
        step(LAT);
        checks++;
        if ({state, ctn} !== {2'd3, 8'd0}) begin
            fails++;
            $display("[TB] FAIL both_haz: got %h want %h", {state, ctn}, {2'd3, 8'd0});
        end
        step(5 * TICK_DIV);
        checks++;
        if ({state, ctn, tick} !== {2'd3, 8'd5, 1'b1}) begin
            fails++;
            $display("[TB] FAIL both_ctn5: got %h want %h", {state, ctn, tick}, {2'd3, 8'd5, 1'b1});
        end
        Resetn = 1'b0;
        step(1);
        obs = {state, ctn, tick, seq_end};
        checks++;
        if (obs !== 12'h000) begin
            fails++;
            $display("[TB] FAIL mid_reset: got %h want 000", obs);
        end
        Resetn = 1'b1;
        left_sw = 1'b0;
        right_sw = 1'b0;
        step(LAT + 2);
        checks++;
        if ({state, ctn, tick} !== 11'h000) begin
            fails++;
            $display("[TB] FAIL post_reset_idle: got %h want 000", {state, ctn, tick});
        end
    endtask

`ifdef THUNDER_DEBOUNCE_EN
    task automatic test_debounce;
        hazard_sw = 1'b1;
        step(1);
        hazard_sw = 1'b0;
        step(1);
        hazard_sw = 1'b1;
        for (int i = 1; i < LAT; i++) begin
            step(1);
            checks++;
            if (state !== 2'd0) begin
                fails++;
                $display("[TB] FAIL bounce_idle cycle %0d: state got %0d want 0", i, state);
            end
        end
        step(1);
        checks++;
        if ({state, ctn} !== {2'd3, 8'd0}) begin
            fails++;
            $display("[TB] FAIL bounce_settle: got %h want %h", {state, ctn}, {2'd3, 8'd0});
        end
        hazard_sw = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_left_sweep;
        test_hazard_preempt;
        test_left_to_idle;
        test_direction_change;
        test_both_then_reset;
`ifdef THUNDER_DEBOUNCE_EN
        test_debounce;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
